mul_div_unit: RTL and testbench

Iterative multiply/divide unit: the sequential companion to the single-cycle ALU. It takes the MULT/MULTU/DIV/DIVU class of operations the ALU does not execute and holds the 64-bit result in architectural HI/LO registers. It sits beside the ALU in the EX stage. The pipeline stalls on `busy` and reads HI/LO through MFHI/MFLO.

---
 rtl/mul_div_unit_pkg.sv | 41 ++++
 rtl/mul_div_unit.sv | 174 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared operation and state encodings for the iterative multiply/divide unit.
//
// Contents:
//   op_e     - MULT, MULTU, DIV, DIVU, MTHI, MTLO operation codes (3 bits)
//   state_e  - IDLE, CALC, FIX sequencer states
//   is_iter_op / is_signed_op / is_mul_op - operation class decoders
package mul_div_unit_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   // Operations that run through the multi-cycle datapath.
   function automatic logic is_iter_op(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
   endfunction

   // Operations whose operands are two's-complement.
   function automatic logic is_signed_op(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic is_mul_op(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// Multiply is shift-add and divide is restoring shift-subtract, both on
// operand magnitudes, one bit per cycle for WIDTH cycles, followed by a
// single sign-fixup cycle that writes HI/LO.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request strobe, honoured only while busy=0
//   op     in   operation select (op_e)
//   a      in   rs: multiplicand / dividend / MTHI-MTLO data
//   b      in   rt: multiplier / divisor
//   busy   out  iterative operation in flight (registered)
//   done   out  one-cycle pulse when a new iterative result is on HI/LO
//   hi     out  HI register (product high half / remainder)
//   lo     out  LO register (product low half / quotient)
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   // Sequencer and datapath state
   state_e               state_q;
   op_e                  op_q;
   logic [2*WIDTH-1:0]   acc_q;     // product accumulator / {remainder, quotient}
   logic [WIDTH-1:0]     opd_q;     // multiplicand or divisor magnitude
   logic [CNT_W-1:0]     count_q;
   logic                 sa_q;
   logic                 sb_q;
   logic                 busy_q;
   logic                 done_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;

   // Combinational next values
   logic                 a_neg_d;
   logic                 b_neg_d;
   logic [WIDTH-1:0]     a_mag_d;
   logic [WIDTH-1:0]     b_mag_d;
   logic [WIDTH:0]       mul_sum_d;
   logic [2*WIDTH-1:0]   mul_step_d;
   logic [WIDTH:0]       div_diff_d;
   logic [2*WIDTH-1:0]   div_step_d;
   logic [2*WIDTH-1:0]   prod_fix_d;
   logic [WIDTH-1:0]     quo_fix_d;
   logic [WIDTH-1:0]     rem_fix_d;
   logic [WIDTH-1:0]     hi_fix_d;
   logic [WIDTH-1:0]     lo_fix_d;

   always_comb begin
      // Operand magnitudes; the most negative value negates to itself,
      // which read as unsigned is already the correct magnitude.
      a_neg_d = is_signed_op(op) & a[WIDTH-1];
      b_neg_d = is_signed_op(op) & b[WIDTH-1];
      a_mag_d = a_neg_d ? -a : a;
      b_mag_d = b_neg_d ? -b : b;

      // Shift-add: multiplier sits in the low half and is consumed LSB
      // first while the partial product shifts in from the top.
      mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_step_d = {mul_sum_d, acc_q[WIDTH-1:1]};

      // Restoring divide: trial-subtract the divisor from the shifted
      // partial remainder; a non-negative difference sets the quotient bit.
      div_diff_d = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
      if (div_diff_d[WIDTH]) begin
         div_step_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
         div_step_d = {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end

      // Sign fixup
      prod_fix_d = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo_fix_d  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix_d  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      if (is_mul_op(op_q)) begin
         hi_fix_d = prod_fix_d[2*WIDTH-1:WIDTH];
         lo_fix_d = prod_fix_d[WIDTH-1:0];
      end else begin
         // A zero divisor leaves the remainder equal to the dividend
         // magnitude, so sign fixup restores a; only LO needs forcing.
         hi_fix_d = rem_fix_d;
         lo_fix_d = (opd_q == '0) ? '1 : quo_fix_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MULT;
         acc_q   <= '0;
         opd_q   <= '0;
         count_q <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (is_iter_op(op)) begin
                     op_q    <= op_e'(op);
                     sa_q    <= a_neg_d;
                     sb_q    <= b_neg_d;
                     if (is_mul_op(op)) begin
                        acc_q <= {{WIDTH{1'b0}}, b_mag_d};
                        opd_q <= a_mag_d;
                     end else begin
                        acc_q <= {{WIDTH{1'b0}}, a_mag_d};
                        opd_q <= b_mag_d;
                     end
                     count_q <= '0;
                     busy_q  <= 1'b1;
                     state_q <= ST_CALC;
                  end else if (op == OP_MTHI) begin
                     hi_q <= a;
                  end else if (op == OP_MTLO) begin
                     lo_q <= a;
                  end
               end
            end

            ST_CALC: begin
               acc_q   <= is_mul_op(op_q) ? mul_step_d : div_step_d;
               count_q <= count_q + CNT_W'(1);
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= ST_FIX;
               end
            end

            ST_FIX: begin
               hi_q    <= hi_fix_d;
               lo_q    <= lo_fix_d;
               count_q <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_tests;
   int          n_fail;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", tag, obs, exp_v);
      end
   endtask

   // Reference {hi,lo} from plain integer arithmetic.
   function automatic logic [63:0] ref_hilo(input logic [2:0] op_in,
                                            input logic [31:0] a_in,
                                            input logic [31:0] b_in);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = longint'($signed(a_in));
      sb = longint'($signed(b_in));
      ua = {32'b0, a_in};
      ub = {32'b0, b_in};
      case (op_in)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b_in == 32'd0) return {a_in, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         OP_DIVU: begin
            if (b_in == 32'd0) return {a_in, 32'hFFFFFFFF};
            q = longint'(ua / ub);
            r = longint'(ua % ub);
            return {r[31:0], q[31:0]};
         end
         default: return {m_hi, m_lo};
      endcase
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle (or after
   // the reset recovery window when inj_rst is set).
   task automatic run_op(input logic [2:0] op_in, input logic [31:0] a_in,
                         input logic [31:0] b_in, input int inj_cyc, input bit inj_rst);
      logic [63:0] exp_hl;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int          cyc;
      int          spurious;
      bit          held;
      bit          aborted;
      exp_hl   = ref_hilo(op_in, a_in, b_in);
      old_hi   = m_hi;
      old_lo   = m_lo;
      cyc      = 0;
      spurious = 0;
      held     = 1'b1;
      aborted  = 1'b0;
      op = op_in; a = a_in; b = b_in; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
         if (hi !== old_hi || lo !== old_lo) held = 1'b0;
         if (done) spurious++;
         if (cyc == inj_cyc) begin
            if (inj_rst) begin
               rst = 1'b1;
               @(posedge clk);
               #1 rst = 1'b0;
               @(negedge clk);
               check("rst_mid_busy", busy, 0);
               check("rst_mid_done", done, 0);
               check("rst_mid_hi", hi, 0);
               check("rst_mid_lo", lo, 0);
               m_hi = '0;
               m_lo = '0;
               repeat (40) begin
                  @(negedge clk);
                  if (done) spurious++;
               end
               check("rst_no_done", spurious, 0);
               aborted = 1'b1;
               break;
            end else begin
               op = OP_MTHI; a = 32'h0000_AAAA; start = 1'b1;
               @(posedge clk);
               #1 start = 1'b0;
            end
         end
      end
      if (!aborted) begin
         check("busy_len", cyc, 33);
         check("done_pulse", done, 1);
         check("hold_hilo", held, 1);
         check("early_done", spurious, 0);
         check("res_hi", hi, exp_hl[63:32]);
         check("res_lo", lo, exp_hl[31:0]);
         m_hi = exp_hl[63:32];
         m_lo = exp_hl[31:0];
      end
   endtask

   task automatic do_mt(input logic [2:0] op_in, input logic [31:0] a_in);
      op = op_in; a = a_in; b = $urandom; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (op_in == OP_MTHI) m_hi = a_in;
      else                  m_lo = a_in;
      @(negedge clk);
      check("mt_busy", busy, 0);
      check("mt_done", done, 0);
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m_hi    = '0;
      m_lo    = '0;
      rst = 1'b1; start = 1'b0; op = OP_MULT; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);

      // Reset beats a simultaneous start
      op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      op = OP_MTHI; a = 32'h5555; start = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; rst = 1'b0; end
      @(negedge clk);
      check("rst_start_busy", busy, 0);
      check("rst_start_hi", hi, 0);

      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0);
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FFF1);
      @(negedge clk);
      check("done_once", done, 0);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check("multu_max_hi", hi, 32'hFFFF_FFFE);
      check("multu_max_lo", lo, 32'h0000_0001);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);

      run_op(OP_DIVU, 32'd7, 32'd0, 0, 0);
      check("divu_zero_lo", lo, 32'hFFFF_FFFF);
      check("divu_zero_hi", hi, 32'd7);

      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'd0);
      do_mt(OP_MTLO, 32'h1234);
      check("mtlo_b2b", lo, 32'h1234);

      run_op(OP_MULT, 32'h0123_4567, 32'h89AB_CDEF, 10, 0);
      check("mthi_ignored", (hi == 32'h0000_AAAA), 0);

      run_op(OP_DIVU, 32'd1000, 32'd7, 15, 1);
      run_op(OP_MULT, 32'd6, 32'd7, 0, 0);
      check("post_rst_lo", lo, 32'd42);
      check("post_rst_hi", hi, 32'd0);

      do_mt(OP_MTHI, $urandom);
      do_mt(OP_MTLO, $urandom);

      for (int n = 0; n < 60; n++) begin
         int unsigned k;
         logic [2:0]  rop;
         k = $urandom_range(0, 9);
         case (k)
            0, 1:    rop = OP_MULT;
            2, 3:    rop = OP_MULTU;
            4, 5:    rop = OP_DIV;
            6, 7:    rop = OP_DIVU;
            8:       rop = OP_MTHI;
            default: rop = OP_MTLO;
         endcase
         if (rop == OP_MTHI || rop == OP_MTLO) begin
            do_mt(rop, rand_operand());
         end else begin
            run_op(rop, rand_operand(), rand_operand(), 0, 0);
            if ($urandom_range(0, 1) == 1) begin
               @(negedge clk);
               check("rand_done_clr", done, 0);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
